three_bus_regfile: RTL and testbench

Parametrised general-purpose register file for the three-bus Mini SRC datapath, replacing the sixteen discrete single-bus register instances with one block. It has two independent read ports (A bus, B bus), a write port (C bus) that can also write a double-width register pair, and a busy scoreboard so that multi-cycle MUL/DIV results can be reserved against later readers. Sits between the select/encode logic, which supplies the addresses, and the ALU operand buses.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/reg_scoreboard.sv | 77 +++++++
 rtl/three_bus_regfile.sv | 103 ++++++++++
 tb/tb_three_bus_regfile.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath constants and helpers for the three-bus Mini SRC register file.
package datapath_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned NREGS_DEF = 16;

  // Mini SRC instruction register field positions (consumed by select/encode logic)
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  // A register pair must start at an even address; only the address LSB matters
  function automatic logic pair_ok(input logic addr_lsb);
    return !addr_lsb;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: tracks registers reserved by multi-cycle ops, raises Stall and error pulses.
module reg_scoreboard
  import datapath_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned AW     = $clog2(NREGS),
  parameter bit          BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] wr_mask,
  input  logic             wr_pair_odd,
  input  logic             rsv_en,
  input  logic             rsv_pair,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             rd_a_en,
  input  logic [AW-1:0]    rd_a_addr,
  input  logic             rd_a_ba,
  input  logic             rd_b_en,
  input  logic [AW-1:0]    rd_b_addr,
  output logic             stall_c,
  output logic             pair_err,
  output logic             rsv_err
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] rsv_mask;
  logic [NREGS-1:0] busy_eff;
  logic             pair_err_q, pair_err_d;
  logic             rsv_err_q, rsv_err_d;

  // Reservation targets, busy update (reserve beats write-clear), error detection and stall
  always_comb begin
    rsv_mask   = '0;
    busy_d     = busy_q;
    busy_eff   = busy_q;
    pair_err_d = 1'b0;
    rsv_err_d  = 1'b0;
    stall_c    = 1'b0;

    if (rsv_en) begin
      rsv_mask[rsv_addr] = 1'b1;
      if (rsv_pair && pair_ok(rsv_addr[0])) begin
        rsv_mask[{rsv_addr[AW-1:1], 1'b1}] = 1'b1;
      end
    end

    busy_d     = (busy_q & ~wr_mask) | rsv_mask;
    rsv_err_d  = |(rsv_mask & busy_q & ~wr_mask);
    pair_err_d = wr_pair_odd || (rsv_en && rsv_pair && !pair_ok(rsv_addr[0]));

    // With bypass, a busy register being written now already delivers fresh data
    if (BYPASS) begin
      busy_eff = busy_q & ~wr_mask;
    end

    stall_c = (rd_a_en && busy_eff[rd_a_addr] && !rd_a_ba) ||
              (rd_b_en && busy_eff[rd_b_addr]);
  end

  // Scoreboard state and error pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      pair_err_q <= 1'b0;
      rsv_err_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      pair_err_q <= pair_err_d;
      rsv_err_q  <= rsv_err_d;
    end
  end

  assign pair_err = pair_err_q;
  assign rsv_err  = rsv_err_q;

endmodule

// File: rtl/three_bus_regfile.sv
// Mini SRC general-purpose register file: two combinational read ports, pair-capable write port.
module three_bus_regfile
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic [AW-1:0]    Rd_A_Addr,
  input  logic             BA_Out,
  output logic [WIDTH-1:0] Rd_A_Data,
  input  logic [AW-1:0]    Rd_B_Addr,
  output logic [WIDTH-1:0] Rd_B_Data,
  input  logic             Wr_En,
  input  logic             Wr_Pair,
  input  logic [AW-1:0]    Wr_Addr,
  input  logic [WIDTH-1:0] Wr_Data,
  input  logic [WIDTH-1:0] Wr_Data_Hi,
  input  logic             Rsv_En,
  input  logic             Rsv_Pair,
  input  logic [AW-1:0]    Rsv_Addr,
  output logic             Stall,
  input  logic             Rd_A_En,
  input  logic             Rd_B_En,
  output logic             Pair_Err,
  output logic             Rsv_Err
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            wr_mask;
  logic                        wr_pair_odd;
  logic                        ba_zero;

  // Write decode: low word always, high word only for an even-address pair
  always_comb begin
    regs_d      = regs_q;
    wr_mask     = '0;
    wr_pair_odd = 1'b0;
    if (Wr_En) begin
      wr_mask[Wr_Addr] = 1'b1;
      regs_d[Wr_Addr]  = Wr_Data;
      if (Wr_Pair) begin
        if (pair_ok(Wr_Addr[0])) begin
          wr_mask[{Wr_Addr[AW-1:1], 1'b1}] = 1'b1;
          regs_d[{Wr_Addr[AW-1:1], 1'b1}]  = Wr_Data_Hi;
        end else begin
          wr_pair_odd = 1'b1;
        end
      end
    end
  end

  // Register storage
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read muxes: base-address zero on A, then optional write bypass, then stored value
  always_comb begin
    ba_zero   = BA_Out && (Rd_A_Addr == '0);
    Rd_A_Data = regs_q[Rd_A_Addr];
    Rd_B_Data = regs_q[Rd_B_Addr];
    if (BYPASS && wr_mask[Rd_A_Addr]) begin
      Rd_A_Data = (Rd_A_Addr == Wr_Addr) ? Wr_Data : Wr_Data_Hi;
    end
    if (BYPASS && wr_mask[Rd_B_Addr]) begin
      Rd_B_Data = (Rd_B_Addr == Wr_Addr) ? Wr_Data : Wr_Data_Hi;
    end
    if (ba_zero) begin
      Rd_A_Data = '0;
    end
  end

  reg_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk         (Clock),
    .rst         (Clear),
    .wr_mask     (wr_mask),
    .wr_pair_odd (wr_pair_odd),
    .rsv_en      (Rsv_En),
    .rsv_pair    (Rsv_Pair),
    .rsv_addr    (Rsv_Addr),
    .rd_a_en     (Rd_A_En),
    .rd_a_addr   (Rd_A_Addr),
    .rd_a_ba     (ba_zero),
    .rd_b_en     (Rd_B_En),
    .rd_b_addr   (Rd_B_Addr),
    .stall_c     (Stall),
    .pair_err    (Pair_Err),
    .rsv_err     (Rsv_Err)
  );

endmodule

// File: tb/tb_three_bus_regfile.sv
// Bench for three_bus_regfile: one BYPASS=1 and one BYPASS=0 instance share all inputs.
module tb_three_bus_regfile;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          clear;
  logic [AW-1:0] rd_a_addr, rd_b_addr, wr_addr, rsv_addr;
  logic          ba_out, rd_a_en, rd_b_en, wr_en, wr_pair, rsv_en, rsv_pair;
  logic [W-1:0]  wr_data, wr_data_hi;

  logic [W-1:0]  rd_a1, rd_b1, rd_a0, rd_b0;
  logic          stall1, stall0, perr1, perr0, rerr1, rerr0;

  // Reference model state
  logic [W-1:0]  m_regs [N];
  bit            m_busy [N];
  bit            exp_perr, exp_rerr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  three_bus_regfile #(.WIDTH(W), .NREGS(N), .BYPASS(1'b1)) dut1 (
    .Clock(clk), .Clear(clear),
    .Rd_A_Addr(rd_a_addr), .BA_Out(ba_out), .Rd_A_Data(rd_a1),
    .Rd_B_Addr(rd_b_addr), .Rd_B_Data(rd_b1),
    .Wr_En(wr_en), .Wr_Pair(wr_pair), .Wr_Addr(wr_addr),
    .Wr_Data(wr_data), .Wr_Data_Hi(wr_data_hi),
    .Rsv_En(rsv_en), .Rsv_Pair(rsv_pair), .Rsv_Addr(rsv_addr),
    .Stall(stall1), .Rd_A_En(rd_a_en), .Rd_B_En(rd_b_en),
    .Pair_Err(perr1), .Rsv_Err(rerr1)
  );

  three_bus_regfile #(.WIDTH(W), .NREGS(N), .BYPASS(1'b0)) dut0 (
    .Clock(clk), .Clear(clear),
    .Rd_A_Addr(rd_a_addr), .BA_Out(ba_out), .Rd_A_Data(rd_a0),
    .Rd_B_Addr(rd_b_addr), .Rd_B_Data(rd_b0),
    .Wr_En(wr_en), .Wr_Pair(wr_pair), .Wr_Addr(wr_addr),
    .Wr_Data(wr_data), .Wr_Data_Hi(wr_data_hi),
    .Rsv_En(rsv_en), .Rsv_Pair(rsv_pair), .Rsv_Addr(rsv_addr),
    .Stall(stall0), .Rd_A_En(rd_a_en), .Rd_B_En(rd_b_en),
    .Pair_Err(perr0), .Rsv_Err(rerr0)
  );

  // ---------------- reference model ----------------
  function automatic bit m_written(input logic [AW-1:0] a);
    if (!wr_en) return 1'b0;
    if (a == wr_addr) return 1'b1;
    return wr_pair && (wr_addr[0] == 1'b0) && (a == 4'(wr_addr + 4'd1));
  endfunction

  function automatic bit m_reserved(input logic [AW-1:0] a);
    if (!rsv_en) return 1'b0;
    if (a == rsv_addr) return 1'b1;
    return rsv_pair && (rsv_addr[0] == 1'b0) && (a == 4'(rsv_addr + 4'd1));
  endfunction

  function automatic logic [W-1:0] m_read(input bit port_a, input logic [AW-1:0] a, input bit byp);
    if (port_a && ba_out && a == 4'd0) return '0;
    if (byp && m_written(a)) return (a == wr_addr) ? wr_data : wr_data_hi;
    return m_regs[a];
  endfunction

  function automatic bit m_stall(input bit byp);
    bit sa, sb;
    sa = rd_a_en && m_busy[rd_a_addr] && !(byp && m_written(rd_a_addr)) &&
         !(ba_out && rd_a_addr == 4'd0);
    sb = rd_b_en && m_busy[rd_b_addr] && !(byp && m_written(rd_b_addr));
    return sa || sb;
  endfunction

  task automatic m_commit();
    bit wr [N];
    bit rv [N];
    for (int i = 0; i < N; i++) begin
      wr[i] = m_written(4'(i));
      rv[i] = m_reserved(4'(i));
    end
    exp_perr = (wr_en && wr_pair && wr_addr[0]) || (rsv_en && rsv_pair && rsv_addr[0]);
    exp_rerr = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (rv[i] && m_busy[i] && !wr[i]) exp_rerr = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (wr[i]) begin
        m_regs[i] = (4'(i) == wr_addr) ? wr_data : wr_data_hi;
        m_busy[i] = 1'b0;
      end
      if (rv[i]) m_busy[i] = 1'b1;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    exp_perr = 1'b0;
    exp_rerr = 1'b0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_a_addr = '0; rd_b_addr = '0; wr_addr = '0; rsv_addr = '0;
    ba_out = 0; rd_a_en = 0; rd_b_en = 0; wr_en = 0; wr_pair = 0;
    rsv_en = 0; rsv_pair = 0; wr_data = '0; wr_data_hi = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_commit();
    #1;
  endtask

  task automatic write1(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    clear = 1'b1;
    m_clear();
    #12;
    n_total++; if (rd_a1 !== 32'h0 || rd_b1 !== 32'h0) $display("FAIL reset_init_data got %h/%h want 0", rd_a1, rd_b1); else n_pass++;
    n_total++; if (stall1 !== 1'b0 || perr1 !== 1'b0 || rerr1 !== 1'b0) $display("FAIL reset_init_flags got %b%b%b want 000", stall1, perr1, rerr1); else n_pass++;
    clear = 1'b0;

    @(negedge clk);
    idle();
    wr_en = 1; wr_pair = 1; wr_addr = 4'd5; wr_data = 32'h1234; wr_data_hi = 32'hFFFF;
    rsv_en = 1; rsv_addr = 4'd2;
    tick();
    n_total++; if (perr1 !== 1'b1) $display("FAIL reset_pre_perr got %b want 1", perr1); else n_pass++;

    @(negedge clk);
    idle();
    rd_a_addr = 4'd5; rd_a_en = 1; rd_b_addr = 4'd2; rd_b_en = 1;
    #1;
    n_total++; if (rd_a1 !== 32'h1234) $display("FAIL reset_pre_r5 got %h want %h", rd_a1, 32'h1234); else n_pass++;
    n_total++; if (stall1 !== 1'b1) $display("FAIL reset_pre_stall got %b want 1", stall1); else n_pass++;
    #1 clear = 1'b1;
    m_clear();
    #1;
    n_total++; if (rd_a1 !== 32'h0 || rd_a0 !== 32'h0) $display("FAIL reset_mid_r5 got %h/%h want 0", rd_a1, rd_a0); else n_pass++;
    n_total++; if (stall1 !== 1'b0 || stall0 !== 1'b0) $display("FAIL reset_mid_stall got %b/%b want 0", stall1, stall0); else n_pass++;
    n_total++; if (perr1 !== 1'b0 || rerr1 !== 1'b0 || perr0 !== 1'b0 || rerr0 !== 1'b0) $display("FAIL reset_mid_flags got %b%b%b%b want 0000", perr1, rerr1, perr0, rerr0); else n_pass++;
    #1 clear = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    write1(4'd3, 32'h0000_0011);
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF; rd_b_addr = 4'd3;
    #1;
    n_total++; if (rd_b1 !== 32'hDEADBEEF) $display("FAIL bypass_on_same got %h want %h", rd_b1, 32'hDEADBEEF); else n_pass++;
    n_total++; if (rd_b0 !== 32'h0000_0011) $display("FAIL bypass_off_same got %h want %h", rd_b0, 32'h11); else n_pass++;
    tick();
    @(negedge clk);
    idle();
    rd_b_addr = 4'd3;
    #1;
    n_total++; if (rd_b0 !== 32'hDEADBEEF) $display("FAIL bypass_off_next got %h want %h", rd_b0, 32'hDEADBEEF); else n_pass++;
  endtask

  task automatic test_ba();
    write1(4'd0, 32'h55);
    @(negedge clk);
    idle();
    ba_out = 1; rd_a_addr = 4'd0; rd_b_addr = 4'd0;
    #1;
    n_total++; if (rd_a1 !== 32'h0 || rd_a0 !== 32'h0) $display("FAIL ba_a_zero got %h/%h want 0", rd_a1, rd_a0); else n_pass++;
    n_total++; if (rd_b1 !== 32'h55 || rd_b0 !== 32'h55) $display("FAIL ba_b_r0 got %h/%h want 55", rd_b1, rd_b0); else n_pass++;
    ba_out = 0;
    #1;
    n_total++; if (rd_a1 !== 32'h55 || rd_a0 !== 32'h55) $display("FAIL ba_off_a got %h/%h want 55", rd_a1, rd_a0); else n_pass++;
  endtask

  task automatic test_pair();
    write1(4'd8, 32'h88);
    @(negedge clk);
    idle();
    wr_en = 1; wr_pair = 1; wr_addr = 4'd6; wr_data = 32'h1; wr_data_hi = 32'h2;
    tick();
    n_total++; if (perr1 !== 1'b0) $display("FAIL pair_even_perr got %b want 0", perr1); else n_pass++;
    @(negedge clk);
    idle();
    rd_a_addr = 4'd6; rd_b_addr = 4'd7;
    #1;
    n_total++; if (rd_a0 !== 32'h1 || rd_b0 !== 32'h2) $display("FAIL pair_even_data got %h/%h want 1/2", rd_a0, rd_b0); else n_pass++;
    wr_en = 1; wr_pair = 1; wr_addr = 4'd7; wr_data = 32'h77; wr_data_hi = 32'h99;
    tick();
    n_total++; if (perr1 !== 1'b1 || perr0 !== 1'b1) $display("FAIL pair_odd_perr got %b/%b want 1", perr1, perr0); else n_pass++;
    @(negedge clk);
    idle();
    rd_a_addr = 4'd7; rd_b_addr = 4'd8;
    #1;
    n_total++; if (rd_a0 !== 32'h77 || rd_b0 !== 32'h88) $display("FAIL pair_odd_data got %h/%h want 77/88", rd_a0, rd_b0); else n_pass++;
    tick();
    n_total++; if (perr1 !== 1'b0) $display("FAIL pair_odd_pulse got %b want 0", perr1); else n_pass++;
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    idle();
    rsv_en = 1; rsv_pair = 1; rsv_addr = 4'd4;
    tick();
    n_total++; if (rerr1 !== 1'b0) $display("FAIL sb_first_rerr got %b want 0", rerr1); else n_pass++;
    @(negedge clk);
    idle();
    rd_a_en = 1; rd_a_addr = 4'd5;
    #1;
    n_total++; if (stall1 !== 1'b1 || stall0 !== 1'b1) $display("FAIL sb_stall got %b/%b want 1", stall1, stall0); else n_pass++;
    wr_en = 1; wr_pair = 1; wr_addr = 4'd4; wr_data = 32'hA4; wr_data_hi = 32'hA5;
    #1;
    n_total++; if (stall1 !== 1'b0 || stall0 !== 1'b1) $display("FAIL sb_write_stall got %b/%b want 0/1", stall1, stall0); else n_pass++;
    tick();
    @(negedge clk);
    idle();
    rd_a_en = 1; rd_a_addr = 4'd5;
    #1;
    n_total++; if (stall1 !== 1'b0 || stall0 !== 1'b0) $display("FAIL sb_cleared got %b/%b want 0", stall1, stall0); else n_pass++;
    rsv_en = 1; rsv_pair = 1; rsv_addr = 4'd4;
    tick();
    @(negedge clk);
    idle();
    rsv_en = 1; rsv_pair = 1; rsv_addr = 4'd4;
    tick();
    n_total++; if (rerr1 !== 1'b1 || rerr0 !== 1'b1) $display("FAIL sb_rerr got %b/%b want 1", rerr1, rerr0); else n_pass++;
    @(negedge clk);
    idle();
    wr_en = 1; wr_pair = 1; wr_addr = 4'd4; wr_data = 32'hB4; wr_data_hi = 32'hB5;
    tick();
    n_total++; if (rerr1 !== 1'b0) $display("FAIL sb_rerr_pulse got %b want 0", rerr1); else n_pass++;
  endtask

  task automatic test_collision();
    @(negedge clk);
    idle();
    wr_en = 1; wr_addr = 4'd9; wr_data = 32'h0ABC;
    rsv_en = 1; rsv_addr = 4'd9;
    tick();
    n_total++; if (rerr1 !== 1'b0 || rerr0 !== 1'b0) $display("FAIL coll_rerr got %b/%b want 0", rerr1, rerr0); else n_pass++;
    @(negedge clk);
    idle();
    rd_b_en = 1; rd_b_addr = 4'd9;
    #1;
    n_total++; if (rd_b1 !== 32'h0ABC || rd_b0 !== 32'h0ABC) $display("FAIL coll_data got %h/%h want abc", rd_b1, rd_b0); else n_pass++;
    n_total++; if (stall1 !== 1'b1 || stall0 !== 1'b1) $display("FAIL coll_busy got %b/%b want 1", stall1, stall0); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] ea1, ea0, eb1, eb0;
    bit es1, es0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rd_a_addr  = 4'($urandom_range(0, 15));
      rd_b_addr  = 4'($urandom_range(0, 15));
      wr_addr    = 4'($urandom_range(0, 15));
      rsv_addr   = 4'($urandom_range(0, 15));
      ba_out     = 1'($urandom_range(0, 1));
      rd_a_en    = 1'($urandom_range(0, 1));
      rd_b_en    = 1'($urandom_range(0, 1));
      wr_en      = 1'($urandom_range(0, 1));
      wr_pair    = 1'($urandom_range(0, 1));
      rsv_en     = ($urandom_range(0, 3) == 0);
      rsv_pair   = 1'($urandom_range(0, 1));
      wr_data    = $urandom;
      wr_data_hi = $urandom;
      #1;
      ea1 = m_read(1'b1, rd_a_addr, 1'b1);
      ea0 = m_read(1'b1, rd_a_addr, 1'b0);
      eb1 = m_read(1'b0, rd_b_addr, 1'b1);
      eb0 = m_read(1'b0, rd_b_addr, 1'b0);
      es1 = m_stall(1'b1);
      es0 = m_stall(1'b0);
      n_total++; if (rd_a1 !== ea1) $display("FAIL rnd_a_byp c=%0d got %h want %h", c, rd_a1, ea1); else n_pass++;
      n_total++; if (rd_a0 !== ea0) $display("FAIL rnd_a_nobyp c=%0d got %h want %h", c, rd_a0, ea0); else n_pass++;
      n_total++; if (rd_b1 !== eb1) $display("FAIL rnd_b_byp c=%0d got %h want %h", c, rd_b1, eb1); else n_pass++;
      n_total++; if (rd_b0 !== eb0) $display("FAIL rnd_b_nobyp c=%0d got %h want %h", c, rd_b0, eb0); else n_pass++;
      n_total++; if (stall1 !== es1) $display("FAIL rnd_stall_byp c=%0d got %b want %b", c, stall1, es1); else n_pass++;
      n_total++; if (stall0 !== es0) $display("FAIL rnd_stall_nobyp c=%0d got %b want %b", c, stall0, es0); else n_pass++;
      tick();
      n_total++; if (perr1 !== exp_perr || perr0 !== exp_perr) $display("FAIL rnd_perr c=%0d got %b/%b want %b", c, perr1, perr0, exp_perr); else n_pass++;
      n_total++; if (rerr1 !== exp_rerr || rerr0 !== exp_rerr) $display("FAIL rnd_rerr c=%0d got %b/%b want %b", c, rerr1, rerr0, exp_rerr); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_ba();
    test_pair();
    test_scoreboard();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
